seq_detect_prog: RTL

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

---
 rtl/seq_detect_pkg.sv | 20 ++
 rtl/seq_detect_prog_if.sv | 28 ++
 rtl/sat_counter.sv | 26 ++
 rtl/seq_detect_prog.sv | 103 ++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared defaults and the pattern-length clamp for the programmable sequence detector.
// Pure declarations: no latency, no flow control.
package seq_detect_pkg;

    localparam int              MAX_PAT_W = 16;
    localparam logic [MAX_PAT_W-1:0] DEF_PAT = 16'h0006;
    localparam int              DEF_LEN   = 4;
    localparam bit              DEF_OVL   = 1'b1;

    // Lengths below 2 or above the history width are pulled into the legal range.
    function automatic int clamp_len(input int len, input int pat_w);
        if (len < 2) begin
            return 2;
        end else if (len > pat_w) begin
            return pat_w;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Serial input, configuration and match outputs of the sequence detector.
// Plain wires: no latency, no flow control.
interface seq_detect_prog_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) ();
    localparam int LW = $clog2(PAT_W + 1);

    logic             en;
    logic             x;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LW-1:0]    cfg_len;
    logic             cfg_ovl;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output en, x, cfg_load, cfg_pat, cfg_len, cfg_ovl,
        input  z, match_cnt, cnt_sat
    );

    modport slave (
        input  en, x, cfg_load, cfg_pat, cfg_len, cfg_ovl,
        output z, match_cnt, cnt_sat
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Count visible one cycle after inc; no backpressure, increments beyond all-ones are dropped.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    assign sat = &cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlap select and saturating match count.
// z is registered one cycle after the final pattern bit; no backpressure, en gates sampling.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_detect_pkg::DEF_PAT),
    parameter int               DEF_LEN = seq_detect_pkg::DEF_LEN,
    parameter bit               DEF_OVL = seq_detect_pkg::DEF_OVL
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_prog_if.slave  bus
);

    localparam int            LW       = $clog2(PAT_W + 1);
    localparam logic [LW-1:0] RST_LEN  = LW'(clamp_len(DEF_LEN, PAT_W));
    localparam logic [LW-1:0] MAX_FILL = LW'(PAT_W);
    localparam logic [LW:0]   ONE_X    = (LW + 1)'(1);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] pat_q;
    logic [LW-1:0]    len_q;
    logic             ovl_q;
    logic [LW-1:0]    fill;
    logic             z_q;

    logic [PAT_W:0]   win;
    logic [PAT_W:0]   mask;
    logic             fill_ok;
    logic             hit;

    // The window carries one bit more than any legal length; the mask always drops its top bit.
    always_comb begin
        win     = {hist, bus.x};
        mask    = '0;
        for (int i = 0; i <= PAT_W; i++) begin
            mask[i] = (i < int'(len_q));
        end
        fill_ok = ({1'b0, fill} + ONE_X) >= {1'b0, len_q};
        hit     = bus.en && fill_ok && (((win ^ {1'b0, pat_q}) & mask) == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= DEF_PAT;
            len_q <= RST_LEN;
            ovl_q <= DEF_OVL;
        end else if (bus.cfg_load) begin
            pat_q <= bus.cfg_pat;
            len_q <= LW'(clamp_len(int'(bus.cfg_len), PAT_W));
            ovl_q <= bus.cfg_ovl;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
        end else if (bus.cfg_load) begin
            hist <= '0;
        end else if (bus.en) begin
            hist <= {hist[PAT_W-2:0], bus.x};
        end
    end

    // Non-overlap mode forgets the bits consumed by a match by emptying the fill count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill <= '0;
        end else if (bus.cfg_load) begin
            fill <= '0;
        end else if (bus.en) begin
            if (hit && !ovl_q) begin
                fill <= '0;
            end else if (fill != MAX_FILL) begin
                fill <= fill + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_q <= 1'b0;
        end else if (bus.cfg_load) begin
            z_q <= 1'b0;
        end else begin
            z_q <= hit;
        end
    end

    assign bus.z = z_q;

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cfg_load),
        .inc (hit),
        .cnt (bus.match_cnt),
        .sat (bus.cnt_sat)
    );

endmodule
